// File: rtl/clock_time_counter.sv
// Time-of-day counter in packed BCD with a tick prescaler and a set mode driven by button pulses.
// CLOCK_12H_EN selects 12-hour format with a live PM flag; when it is undefined, hours run 00-23.
module clock_time_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_set_en,
  input  logic       i_inc_min,
  input  logic       i_inc_hr,
  output logic [7:0] o_sec_bcd,
  output logic [7:0] o_min_bcd,
  output logic [7:0] o_hr_bcd,
  output logic       o_pm,
  output logic       o_day_tick
);

`ifdef CLOCK_12H_EN
  localparam bit         HR12     = 1'b1;
  localparam logic [7:0] HR_RESET = 8'h12;
  localparam logic [7:0] HR_LAST  = 8'h11;
`else
  localparam bit         HR12     = 1'b0;
  localparam logic [7:0] HR_RESET = 8'h00;
  localparam logic [7:0] HR_LAST  = 8'h23;
`endif

  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

  logic [7:0] presc_q, presc_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hr_q, hr_d;
  logic       pm_q, pm_d;
  logic       day_q, day_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] ms_inc(input logic [7:0] v);
    return (v == 8'h59) ? 8'h00 : bcd_inc(v);
  endfunction

  // 12-hour sequence is 12, 01 .. 11; 24-hour sequence is 00 .. 23.
  function automatic logic [7:0] hr_inc(input logic [7:0] v);
    if (HR12) return (v == 8'h12) ? 8'h01 : bcd_inc(v);
    else      return (v == 8'h23) ? 8'h00 : bcd_inc(v);
  endfunction

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pm_d    = pm_q;
    day_d   = 1'b0;
    if (i_set_en) begin
      presc_d = 8'd0;
      sec_d   = 8'h00;
      if (i_inc_min) min_d = ms_inc(min_q);
      if (i_inc_hr) begin
        hr_d = hr_inc(hr_q);
        if (HR12 && hr_q == 8'h11) pm_d = ~pm_q;
      end
    end else if (i_tick) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = 8'd0;
        sec_d   = ms_inc(sec_q);
        if (sec_q == 8'h59) begin
          min_d = ms_inc(min_q);
          if (min_q == 8'h59) begin
            hr_d = hr_inc(hr_q);
            if (HR12 && hr_q == 8'h11) pm_d = ~pm_q;
            // Midnight: last hour of the day, and in 12-hour mode only the PM half.
            day_d = (hr_q == HR_LAST) && (!HR12 || pm_q);
          end
        end
      end else begin
        presc_d = 8'(presc_q + 8'd1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q <= 8'd0;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hr_q    <= HR_RESET;
      pm_q    <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pm_q    <= pm_d;
      day_q   <= day_d;
    end
  end

  assign o_sec_bcd  = sec_q;
  assign o_min_bcd  = min_q;
  assign o_hr_bcd   = hr_q;
  assign o_pm       = pm_q;
  assign o_day_tick = day_q;

endmodule
